// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: field widths and the write-data / load-kind encodings.
package mips_pkg;

    localparam int REG_AW = 5;
    localparam int XLEN   = 32;

    localparam logic [2:0] WDSEL_ALU  = 3'd0;
    localparam logic [2:0] WDSEL_DM   = 3'd1;
    localparam logic [2:0] WDSEL_PC8  = 3'd2;
    localparam logic [2:0] WDSEL_HILO = 3'd3;

    localparam logic [2:0] LD_LW  = 3'd0;
    localparam logic [2:0] LD_LB  = 3'd1;
    localparam logic [2:0] LD_LBU = 3'd2;
    localparam logic [2:0] LD_LH  = 3'd3;
    localparam logic [2:0] LD_LHU = 3'd4;

endpackage

// File: rtl/load_ext.sv
// Little-endian load extraction with sign/zero extension; purely combinational.
module load_ext
    import mips_pkg::*;
(
    input  logic [XLEN-1:0] dmrd,
    input  logic [1:0]      addr_lo,
    input  logic [2:0]      ldtype,
    output logic [XLEN-1:0] value
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = dmrd[8*addr_lo +: 8];
        // Halfword alignment uses only addr_lo[1]; an odd byte offset is ignored.
        half_sel = addr_lo[1] ? dmrd[31:16] : dmrd[15:0];
        case (ldtype)
            LD_LB:   value = {{24{byte_sel[7]}}, byte_sel};
            LD_LBU:  value = {24'd0, byte_sel};
            LD_LH:   value = {{16{half_sel[15]}}, half_sel};
            LD_LHU:  value = {16'd0, half_sel};
            default: value = dmrd;
        endcase
    end

endmodule

// File: rtl/w_stage.sv
// MIPS writeback stage: M/W pipeline register, write-data select, GRF write port and retire counter.
module w_stage
    import mips_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC8 = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m_valid,
    input  logic              m_regwrite,
    input  logic [REG_AW-1:0] m_wa,
    input  logic [2:0]        m_wdsel,
    input  logic [2:0]        m_ldtype,
    input  logic [XLEN-1:0]   m_alu,
    input  logic [1:0]        m_addr_lo,
    input  logic [XLEN-1:0]   m_dmrd,
    input  logic [XLEN-1:0]   m_hilo,
    input  logic [XLEN-1:0]   m_pc8,
    output logic              regwrite,
    output logic [REG_AW-1:0] wa,
    output logic [XLEN-1:0]   wd,
    output logic [XLEN-1:0]   pc8,
    output logic              fwd_valid,
    output logic [XLEN-1:0]   instret
);

    // Handshake: m_valid qualifies the M slot each cycle; there is no ready, W always accepts.
    logic              regwrite_q, regwrite_d;
    logic [REG_AW-1:0] wa_q;
    logic [2:0]        wdsel_q, ldtype_q;
    logic [XLEN-1:0]   alu_q, dmrd_q, hilo_q, pc8_q;
    logic [1:0]        addr_lo_q;
    logic [XLEN-1:0]   instret_q, instret_d;
    logic [XLEN-1:0]   load_val;

    always_comb begin
        regwrite_d = m_valid && m_regwrite && (m_wa != '0);
        instret_d  = m_valid ? instret_q + 32'd1 : instret_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regwrite_q <= 1'b0;
            wa_q       <= '0;
            wdsel_q    <= '0;
            ldtype_q   <= '0;
            alu_q      <= '0;
            addr_lo_q  <= '0;
            dmrd_q     <= '0;
            hilo_q     <= '0;
            pc8_q      <= RESET_PC8;
            instret_q  <= '0;
        end else begin
            regwrite_q <= regwrite_d;
            wa_q       <= m_wa;
            wdsel_q    <= m_wdsel;
            ldtype_q   <= m_ldtype;
            alu_q      <= m_alu;
            addr_lo_q  <= m_addr_lo;
            dmrd_q     <= m_dmrd;
            hilo_q     <= m_hilo;
            pc8_q      <= m_pc8;
            instret_q  <= instret_d;
        end
    end

    load_ext u_load_ext (
        .dmrd    (dmrd_q),
        .addr_lo (addr_lo_q),
        .ldtype  (ldtype_q),
        .value   (load_val)
    );

    // Write data depends only on flops so the forwarding path starts fresh each cycle.
    always_comb begin
        case (wdsel_q)
            WDSEL_DM:   wd = load_val;
            WDSEL_PC8:  wd = pc8_q;
            WDSEL_HILO: wd = hilo_q;
            default:    wd = alu_q;
        endcase
    end

    assign regwrite  = regwrite_q;
    assign wa        = wa_q;
    assign pc8       = pc8_q;
    assign fwd_valid = regwrite_q && (wa_q != '0);
    assign instret   = instret_q;

endmodule
